// File: rtl/alarm_match_unit_if.sv
// rtl/alarm_match_unit_if.sv - keypad control, time counter and buzzer signals of the alarm match unit
interface alarm_match_unit_if;
  logic       setalarm;
  logic [7:0] alarm_hr_in;
  logic [7:0] alarm_min_in;
  logic       enablealarm;
  logic [7:0] cur_hr;
  logic [7:0] cur_min;
  logic       sec_tick;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic       armed;
  logic       snoozing;
  logic [7:0] alm_hr;
  logic [7:0] alm_min;

  modport master (
    output setalarm, alarm_hr_in, alarm_min_in, enablealarm,
    output cur_hr, cur_min, sec_tick, stop, snooze,
    input  buzzer, armed, snoozing, alm_hr, alm_min
  );

  modport slave (
    input  setalarm, alarm_hr_in, alarm_min_in, enablealarm,
    input  cur_hr, cur_min, sec_tick, stop, snooze,
    output buzzer, armed, snoozing, alm_hr, alm_min
  );
endinterface

// File: rtl/alarm_match_unit.sv
// rtl/alarm_match_unit.sv - alarm time store, BCD time compare and buzzer FSM
// Optional snooze state and BCD snooze adder are built only when SNOOZE_EN is defined.
module alarm_match_unit #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic               clk,
  input  logic               reset,
  alarm_match_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  state_t     state, state_n;
  logic       valid, setalarm_d, match_d;
  logic [7:0] alm_hr_q, alm_min_q;
  logic [7:0] tgt_hr, tgt_min, tgt_hr_n, tgt_min_n;
  logic [7:0] cnt;
  logic       load_edge, match_edge, armed_c, ring_done;

  assign load_edge  = bus.setalarm & ~setalarm_d;
  assign armed_c    = valid & bus.enablealarm;
  assign match_edge = (bus.cur_hr == tgt_hr) && (bus.cur_min == tgt_min) && !match_d;
  assign ring_done  = bus.sec_tick && (cnt == RING_LAST);

`ifdef SNOOZE_EN
  localparam logic [7:0] SNZ = 8'(SNOOZE_MIN);

  logic [7:0] snz_m, snz_h, snz_hr, snz_min;

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] b);
    return {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  // Snooze target is built on the current target so repeated snoozes accumulate.
  always_comb begin
    snz_m = bcd_to_bin(tgt_min) + SNZ;
    snz_h = bcd_to_bin(tgt_hr);
    if (snz_m >= 8'd60) begin
      snz_m = snz_m - 8'd60;
      snz_h = snz_h + 8'd1;
    end
    if (snz_h >= 8'd24) snz_h = snz_h - 8'd24;
    snz_hr  = bin_to_bcd(snz_h);
    snz_min = bin_to_bcd(snz_m);
  end
`else
  logic unused_snooze;
  assign unused_snooze = bus.snooze | (SNOOZE_MIN == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (load_edge) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (match_edge && armed_c) state_n = RINGING;
        RINGING: begin
          if (!bus.enablealarm || bus.stop) state_n = IDLE;
`ifdef SNOOZE_EN
          else if (bus.snooze)              state_n = SNOOZE;
`endif
          else if (ring_done)               state_n = IDLE;
        end
`ifdef SNOOZE_EN
        SNOOZE: begin
          if (!bus.enablealarm || bus.stop) state_n = IDLE;
          else if (match_edge)              state_n = RINGING;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.buzzer   = (state == RINGING);
    bus.armed    = armed_c;
    bus.snoozing = 1'b0;
`ifdef SNOOZE_EN
    bus.snoozing = (state == SNOOZE);
`endif
    bus.alm_hr   = alm_hr_q;
    bus.alm_min  = alm_min_q;
  end

  // Any return to IDLE drops the snooze offset and compares against the stored alarm again.
  always_comb begin
    tgt_hr_n  = tgt_hr;
    tgt_min_n = tgt_min;
    if (load_edge) begin
      tgt_hr_n  = bus.alarm_hr_in;
      tgt_min_n = bus.alarm_min_in;
    end else if (state_n == IDLE && state != IDLE) begin
      tgt_hr_n  = alm_hr_q;
      tgt_min_n = alm_min_q;
    end
`ifdef SNOOZE_EN
    else if (state_n == SNOOZE && state == RINGING) begin
      tgt_hr_n  = snz_hr;
      tgt_min_n = snz_min;
    end
`endif
  end

  // match_d is taken against the next target, so a target change never creates a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      setalarm_d <= 1'b0;
      match_d    <= 1'b0;
      valid      <= 1'b0;
      alm_hr_q   <= 8'h00;
      alm_min_q  <= 8'h00;
      tgt_hr     <= 8'h00;
      tgt_min    <= 8'h00;
      cnt        <= 8'd0;
    end else begin
      setalarm_d <= bus.setalarm;
      match_d    <= (bus.cur_hr == tgt_hr_n) && (bus.cur_min == tgt_min_n);
      if (load_edge) begin
        alm_hr_q  <= bus.alarm_hr_in;
        alm_min_q <= bus.alarm_min_in;
        valid     <= 1'b1;
      end
      tgt_hr  <= tgt_hr_n;
      tgt_min <= tgt_min_n;
      if (state_n == RINGING && state != RINGING) cnt <= 8'd0;
      else if (state == RINGING && bus.sec_tick)  cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alarm_match_unit.sv
// tb/tb_alarm_match_unit.sv - randomized and directed bench for alarm_match_unit with a minutes-of-day model
module tb_alarm_match_unit;
  localparam int RS = 60;
  localparam int SM = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_match_unit_if bus ();

  alarm_match_unit #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef enum {M_IDLE, M_RING, M_SNZ} mstate_t;
  mstate_t    m_state;
  bit         m_valid;
  logic [7:0] m_alm_hr, m_alm_min;
  int         m_tgt, m_cnt, m_prev_cur;
  bit         m_prev_set;

  function automatic int to_min(input logic [7:0] h, input logic [7:0] m);
    return (int'(h[7:4]) * 10 + int'(h[3:0])) * 60 + int'(m[7:4]) * 10 + int'(m[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic set_cur(input int t);
    bus.cur_hr  = bcd(t / 60);
    bus.cur_min = bcd(t % 60);
  endtask

  task automatic set_alarm_in(input int t);
    bus.alarm_hr_in  = bcd(t / 60);
    bus.alarm_min_in = bcd(t % 60);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Alarm behaviour in terms of minutes of the day; a ring fires when cur has just become the target.
  task automatic model_step();
    int cur;
    bit hit, load, was_idle;
    if (reset) begin
      m_state = M_IDLE; m_valid = 0; m_alm_hr = 8'h00; m_alm_min = 8'h00;
      m_tgt = 0; m_cnt = 0; m_prev_cur = -1; m_prev_set = 0;
      return;
    end
    cur      = to_min(bus.cur_hr, bus.cur_min);
    hit      = (cur == m_tgt) && (m_prev_cur != m_tgt);
    load     = bus.setalarm && !m_prev_set;
    was_idle = (m_state == M_IDLE);
    if (load) begin
      m_alm_hr  = bus.alarm_hr_in;
      m_alm_min = bus.alarm_min_in;
      m_valid   = 1;
      m_tgt     = to_min(m_alm_hr, m_alm_min);
      m_state   = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: if (hit && m_valid && bus.enablealarm) begin m_state = M_RING; m_cnt = 0; end
        M_RING: begin
          if (!bus.enablealarm || bus.stop) m_state = M_IDLE;
`ifdef SNOOZE_EN
          else if (bus.snooze) begin m_state = M_SNZ; m_tgt = (m_tgt + SM) % 1440; end
`endif
          else if (bus.sec_tick) begin
            if (m_cnt == RS - 1) m_state = M_IDLE;
            else m_cnt++;
          end
        end
        M_SNZ: begin
          if (!bus.enablealarm || bus.stop) m_state = M_IDLE;
          else if (hit) begin m_state = M_RING; m_cnt = 0; end
        end
        default: m_state = M_IDLE;
      endcase
      if (!was_idle && m_state == M_IDLE) m_tgt = to_min(m_alm_hr, m_alm_min);
    end
    m_prev_cur = cur;
    m_prev_set = bus.setalarm;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("buzzer",   8'(bus.buzzer),   8'(m_state == M_RING));
    check("armed",    8'(bus.armed),    8'(m_valid && bus.enablealarm));
    check("snoozing", 8'(bus.snoozing), 8'(m_state == M_SNZ));
    check("alm_hr",   bus.alm_hr,  m_alm_hr);
    check("alm_min",  bus.alm_min, m_alm_min);
  endtask

  initial begin
    reset = 1'b1;
    bus.setalarm = 0; bus.enablealarm = 0; bus.sec_tick = 0; bus.stop = 0; bus.snooze = 0;
    set_cur(0); set_alarm_in(0);
    cycle(); cycle();
    check("rst_buzzer", 8'(bus.buzzer), 8'd0);
    check("rst_armed",  8'(bus.armed),  8'd0);
    check("rst_alm_hr", bus.alm_hr, 8'h00);

    // 07:30 alarm, ring on the minute change, stop, no retrigger within the minute
    reset = 1'b0; bus.enablealarm = 1;
    set_alarm_in(7 * 60 + 30); set_cur(7 * 60 + 29); bus.setalarm = 1;
    cycle();
    check("load_hr",    bus.alm_hr,  8'h07);
    check("load_min",   bus.alm_min, 8'h30);
    check("load_armed", 8'(bus.armed), 8'd1);
    bus.setalarm = 0; cycle();
    set_cur(450); cycle();
    check("ring_on", 8'(bus.buzzer), 8'd1);
    bus.stop = 1; cycle(); bus.stop = 0;
    check("stop_off", 8'(bus.buzzer), 8'd0);
    repeat (5) cycle();
    check("no_retrigger", 8'(bus.buzzer), 8'd0);

    // auto-stop after RS sec ticks
    set_cur(451); cycle(); set_cur(450); cycle();
    check("ring2_on", 8'(bus.buzzer), 8'd1);
    for (int i = 1; i <= RS; i++) begin
      bus.sec_tick = 1; cycle(); bus.sec_tick = 0;
      if (i == RS - 1) check("before_last_tick", 8'(bus.buzzer), 8'd1);
      if (i == RS)     check("auto_stop",        8'(bus.buzzer), 8'd0);
      cycle();
    end

    // reset while ringing
    set_cur(451); cycle(); set_cur(450); cycle();
    check("ring3_on", 8'(bus.buzzer), 8'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_ring_buzzer", 8'(bus.buzzer), 8'd0);
    check("rst_ring_armed",  8'(bus.armed),  8'd0);
    check("rst_ring_min",    bus.alm_min, 8'h00);

    // loading the current minute must not ring; disabled alarm must not ring
    set_cur(720); cycle();
    set_alarm_in(720); bus.setalarm = 1; cycle(); bus.setalarm = 0;
    repeat (3) cycle();
    check("load_in_minute", 8'(bus.buzzer), 8'd0);
    bus.enablealarm = 0; set_cur(719); cycle(); set_cur(720); cycle();
    check("disabled_no_ring", 8'(bus.buzzer), 8'd0);
    check("disabled_armed",   8'(bus.armed),  8'd0);
    bus.enablealarm = 1; repeat (3) cycle();
    check("reenable_no_ring", 8'(bus.buzzer), 8'd0);

    // stop and snooze together while ringing
    set_cur(719); cycle(); set_cur(720); cycle();
    check("ring4_on", 8'(bus.buzzer), 8'd1);
    bus.stop = 1; bus.snooze = 1; cycle(); bus.stop = 0; bus.snooze = 0;
    check("stop_snooze_buzzer",   8'(bus.buzzer),   8'd0);
    check("stop_snooze_snoozing", 8'(bus.snoozing), 8'd0);

`ifdef SNOOZE_EN
    set_alarm_in(23 * 60 + 58); bus.setalarm = 1; set_cur(23 * 60 + 57); cycle(); bus.setalarm = 0; cycle();
    set_cur(1438); cycle();
    check("snz_ring_on", 8'(bus.buzzer), 8'd1);
    bus.snooze = 1; cycle(); bus.snooze = 0;
    check("snz_snoozing", 8'(bus.snoozing), 8'd1);
    check("snz_quiet",    8'(bus.buzzer),   8'd0);
    set_cur(3); cycle();
    check("snz_rering_0003", 8'(bus.buzzer), 8'd1);
    bus.snooze = 1; cycle(); bus.snooze = 0;
    set_cur(7); cycle();
    check("snz_not_0007", 8'(bus.buzzer), 8'd0);
    set_cur(8); cycle();
    check("snz_rering_0008", 8'(bus.buzzer), 8'd1);
    bus.stop = 1; cycle(); bus.stop = 0;
    check("snz_stop", 8'(bus.snoozing), 8'd0);
    set_cur(1437); cycle(); set_cur(1438); cycle();
    bus.snooze = 1; cycle(); bus.snooze = 0;
    check("snz_again", 8'(bus.snoozing), 8'd1);
    set_alarm_in(6 * 60 + 15); bus.setalarm = 1; cycle(); bus.setalarm = 0;
    check("snz_load_idle", 8'(bus.snoozing), 8'd0);
    check("snz_load_hr",   bus.alm_hr,  8'h06);
    check("snz_load_min",  bus.alm_min, 8'h15);
`endif

    // randomized phase; cur mostly wanders around the model's target to provoke rings
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) begin
        bus.setalarm = ~bus.setalarm;
        if (bus.setalarm) set_alarm_in(int'($urandom_range(0, 1439)));
      end
      if ($urandom_range(0, 99) == 0) bus.enablealarm = ~bus.enablealarm;
      if ($urandom_range(0, 3) == 0)
        set_cur((m_tgt + 1440 + int'($urandom_range(0, 4)) - 2) % 1440);
      else if ($urandom_range(0, 19) == 0)
        set_cur(int'($urandom_range(0, 1439)));
      bus.sec_tick = ($urandom_range(0, 2) == 0);
      bus.stop     = ($urandom_range(0, 299) == 0);
      bus.snooze   = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
